// File: rtl/matrix_pkg.sv
// Shared types and helpers for the matrix multiply engine: FSM states, read-tag
// record and the output saturation function.
package matrix_pkg;

    localparam int unsigned TagKWidth = 8;
    localparam int unsigned SatWidth  = 64;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StDrain,
        StWrite
    } state_e;

    typedef struct packed {
        logic                 valid;
        logic                 first;
        logic [TagKWidth-1:0] k;
    } tag_t;

    // acc arrives already sign/zero-extended to SatWidth; caller keeps the low dw bits.
    function automatic logic [SatWidth-1:0] saturate(
        input logic [SatWidth-1:0] acc,
        input int unsigned         dw,
        input logic                is_signed,
        input logic                sat_en
    );
        logic [SatWidth-1:0] hi;
        logic [SatWidth-1:0] lo;
        if (!sat_en) begin
            return acc;
        end
        if (is_signed) begin
            hi = (SatWidth'(1) << (dw - 1)) - SatWidth'(1);
            lo = ~hi;
            if ($signed(acc) > $signed(hi)) begin
                return hi;
            end
            if ($signed(acc) < $signed(lo)) begin
                return lo;
            end
            return acc;
        end
        hi = (SatWidth'(1) << dw) - SatWidth'(1);
        return (acc > hi) ? hi : acc;
    endfunction

endpackage

// File: rtl/mac_lane.sv
// One multiply-accumulate lane: products are extended to the accumulator width
// according to the operand signedness, then loaded or accumulated.
module mac_lane #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ACC_WIDTH  = 35
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_en,
    input  logic                  i_first,
    input  logic                  i_signed_mode,
    input  logic [DATA_WIDTH-1:0] i_a,
    input  logic [DATA_WIDTH-1:0] i_b,
    output logic [ACC_WIDTH-1:0]  o_acc
);

    logic [ACC_WIDTH-1:0] w_a_ext;
    logic [ACC_WIDTH-1:0] w_b_ext;
    logic [ACC_WIDTH-1:0] w_prod;
    logic [ACC_WIDTH-1:0] r_acc;

    // Extending both operands first keeps the truncated product exact in either mode.
    assign w_a_ext = {{(ACC_WIDTH-DATA_WIDTH){i_signed_mode & i_a[DATA_WIDTH-1]}}, i_a};
    assign w_b_ext = {{(ACC_WIDTH-DATA_WIDTH){i_signed_mode & i_b[DATA_WIDTH-1]}}, i_b};
    assign w_prod  = w_a_ext * w_b_ext;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= i_first ? w_prod : r_acc + w_prod;
        end
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/matrix_multiply_engine.sv
// Row-by-row rectangular matrix multiplier C = A x B with pipelined row reads,
// per-lane MACs, optional saturation and a ready/write handshake on C rows.
module matrix_multiply_engine
    import matrix_pkg::*;
#(
    parameter int unsigned MAX_DIM      = 8,
    parameter int unsigned DIM_WIDTH    = $clog2(MAX_DIM),
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned DATA_WIDTH   = 16,
    parameter int unsigned ACC_WIDTH    = 2 * DATA_WIDTH + $clog2(MAX_DIM),
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic                            i_clk,
    input  logic                            i_reset,
    input  logic                            i_start,
    input  logic [DIM_WIDTH-1:0]            i_dim_m,
    input  logic [DIM_WIDTH-1:0]            i_dim_k,
    input  logic [DIM_WIDTH-1:0]            i_dim_n,
    input  logic                            i_signed_mode,
    input  logic                            i_sat_mode,
    output logic [ADDR_WIDTH-1:0]           o_mat_a_address,
    input  logic [DATA_WIDTH*MAX_DIM-1:0]   i_mat_a_read_data,
    output logic [ADDR_WIDTH-1:0]           o_mat_b_address,
    input  logic [DATA_WIDTH*MAX_DIM-1:0]   i_mat_b_read_data,
    output logic                            o_mat_c_write,
    input  logic                            i_mat_c_ready,
    output logic [ADDR_WIDTH-1:0]           o_mat_c_address,
    output logic [DATA_WIDTH*MAX_DIM-1:0]   o_mat_c_write_data,
    output logic [MAX_DIM-1:0]              o_mat_c_lane_mask,
    output logic                            o_busy,
    output logic                            o_done
);

    localparam int unsigned DrainWidth = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam logic [DrainWidth-1:0] DrainLast = DrainWidth'(READ_LATENCY - 1);

    state_e                 r_state;
    state_e                 w_state_d;
    logic                   w_done_d;
    logic                   r_done;
    logic [DIM_WIDTH-1:0]   r_i;
    logic [DIM_WIDTH-1:0]   r_k;
    logic [DIM_WIDTH-1:0]   r_dim_m;
    logic [DIM_WIDTH-1:0]   r_dim_k;
    logic [DIM_WIDTH-1:0]   r_dim_n;
    logic                   r_signed;
    logic                   r_sat;
    logic [DrainWidth-1:0]  r_drain;
    tag_t                   r_tag [READ_LATENCY];
    tag_t                   w_tag_in;
    tag_t                   w_tag;
    logic [DATA_WIDTH-1:0]  w_a_elem;
    logic [ACC_WIDTH-1:0]   w_acc [MAX_DIM];
    logic [MAX_DIM-1:0]     w_mask;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_done_d  = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (i_start) begin
                    w_state_d = StIssue;
                end
            end
            StIssue: begin
                if (r_k == r_dim_k) begin
                    w_state_d = StDrain;
                end
            end
            StDrain: begin
                if (r_drain == DrainLast) begin
                    w_state_d = StWrite;
                end
            end
            StWrite: begin
                if (i_mat_c_ready) begin
                    if (r_i == r_dim_m) begin
                        w_state_d = StIdle;
                        w_done_d  = 1'b1;
                    end else begin
                        w_state_d = StIssue;
                    end
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_done   <= 1'b0;
            r_i      <= '0;
            r_k      <= '0;
            r_dim_m  <= '0;
            r_dim_k  <= '0;
            r_dim_n  <= '0;
            r_signed <= 1'b0;
            r_sat    <= 1'b0;
            r_drain  <= '0;
        end else begin
            r_done  <= w_done_d;
            r_drain <= (r_state == StDrain) ? r_drain + 1'b1 : '0;
            case (r_state)
                StIdle: begin
                    if (i_start) begin
                        r_dim_m  <= i_dim_m;
                        r_dim_k  <= i_dim_k;
                        r_dim_n  <= i_dim_n;
                        r_signed <= i_signed_mode;
                        r_sat    <= i_sat_mode;
                        r_i      <= '0;
                        r_k      <= '0;
                    end
                end
                StIssue: begin
                    if (r_k != r_dim_k) begin
                        r_k <= r_k + 1'b1;
                    end
                end
                StWrite: begin
                    if (i_mat_c_ready && (r_i != r_dim_m)) begin
                        r_i <= r_i + 1'b1;
                        r_k <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Tags travel alongside the memory reads so each returning row knows its k.
    assign w_tag_in.valid = (r_state == StIssue);
    assign w_tag_in.first = (r_k == '0);
    assign w_tag_in.k     = TagKWidth'(r_k);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int n = 0; n < READ_LATENCY; n++) begin
                r_tag[n] <= '0;
            end
        end else begin
            r_tag[0] <= w_tag_in;
            for (int n = 1; n < READ_LATENCY; n++) begin
                r_tag[n] <= r_tag[n-1];
            end
        end
    end

    assign w_tag = r_tag[READ_LATENCY-1];

    always_comb begin
        w_a_elem = '0;
        for (int unsigned j = 0; j < MAX_DIM; j++) begin
            if (w_tag.k == TagKWidth'(j)) begin
                w_a_elem = i_mat_a_read_data[j*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    for (genvar j = 0; j < MAX_DIM; j++) begin : g_lane
        logic [SatWidth-1:0]   w_acc_ext;
        logic [DATA_WIDTH-1:0] w_conv;

        mac_lane #(
            .DATA_WIDTH (DATA_WIDTH),
            .ACC_WIDTH  (ACC_WIDTH)
        ) u_mac_lane (
            .i_clk         (i_clk),
            .i_reset       (i_reset),
            .i_en          (w_tag.valid),
            .i_first       (w_tag.first),
            .i_signed_mode (r_signed),
            .i_a           (w_a_elem),
            .i_b           (i_mat_b_read_data[j*DATA_WIDTH +: DATA_WIDTH]),
            .o_acc         (w_acc[j])
        );

        assign w_acc_ext = {{(SatWidth-ACC_WIDTH){r_signed & w_acc[j][ACC_WIDTH-1]}}, w_acc[j]};
        assign w_conv    = DATA_WIDTH'(saturate(w_acc_ext, DATA_WIDTH, r_signed, r_sat));
        assign w_mask[j] = (DIM_WIDTH'(j) <= r_dim_n);
        assign o_mat_c_write_data[j*DATA_WIDTH +: DATA_WIDTH] = w_mask[j] ? w_conv : '0;
    end

    assign o_mat_a_address   = ADDR_WIDTH'(r_i);
    assign o_mat_b_address   = ADDR_WIDTH'(r_k);
    assign o_mat_c_address   = ADDR_WIDTH'(r_i);
    assign o_mat_c_lane_mask = w_mask;
    assign o_mat_c_write     = (r_state == StWrite);
    assign o_busy            = (r_state != StIdle);
    assign o_done            = r_done;

endmodule

// File: tb/tb_matrix_multiply_engine.sv
// Scoreboard bench: two engines (read latency 1 and 3) share stimulus and memory
// contents; expected C rows are queued at job start and popped on each handshake.
module tb_matrix_multiply_engine;

    localparam int unsigned MD  = 8;
    localparam int unsigned DW  = 16;
    localparam int unsigned RW  = DW * MD;

    typedef struct {
        logic [31:0]   addr;
        logic [RW-1:0] data;
        logic [MD-1:0] mask;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic [2:0] dim_m = '0, dim_k = '0, dim_n = '0;
    logic signed_mode = 1'b0, sat_mode = 1'b0, ready = 1'b1;

    logic [31:0]   a_addr1, b_addr1, c_addr1, a_addr3, b_addr3, c_addr3;
    logic [RW-1:0] a_rd1, b_rd1, c_data1, c_data3;
    logic [RW-1:0] a_pipe3 [3];
    logic [RW-1:0] b_pipe3 [3];
    logic [MD-1:0] c_mask1, c_mask3;
    logic          c_write1, c_write3, busy1, busy3, done1, done3;

    logic [DW-1:0] mem_a [MD][MD];
    logic [DW-1:0] mem_b [MD][MD];

    exp_t q1[$];
    exp_t q3[$];
    exp_t e1, e3;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    matrix_multiply_engine #(.READ_LATENCY(1)) u_dut1 (
        .i_clk(clk), .i_reset(reset), .i_start(start),
        .i_dim_m(dim_m), .i_dim_k(dim_k), .i_dim_n(dim_n),
        .i_signed_mode(signed_mode), .i_sat_mode(sat_mode),
        .o_mat_a_address(a_addr1), .i_mat_a_read_data(a_rd1),
        .o_mat_b_address(b_addr1), .i_mat_b_read_data(b_rd1),
        .o_mat_c_write(c_write1), .i_mat_c_ready(ready),
        .o_mat_c_address(c_addr1), .o_mat_c_write_data(c_data1),
        .o_mat_c_lane_mask(c_mask1), .o_busy(busy1), .o_done(done1)
    );

    matrix_multiply_engine #(.READ_LATENCY(3)) u_dut3 (
        .i_clk(clk), .i_reset(reset), .i_start(start),
        .i_dim_m(dim_m), .i_dim_k(dim_k), .i_dim_n(dim_n),
        .i_signed_mode(signed_mode), .i_sat_mode(sat_mode),
        .o_mat_a_address(a_addr3), .i_mat_a_read_data(a_pipe3[2]),
        .o_mat_b_address(b_addr3), .i_mat_b_read_data(b_pipe3[2]),
        .o_mat_c_write(c_write3), .i_mat_c_ready(ready),
        .o_mat_c_address(c_addr3), .o_mat_c_write_data(c_data3),
        .o_mat_c_lane_mask(c_mask3), .o_busy(busy3), .o_done(done3)
    );

    function automatic logic [RW-1:0] row_a(input logic [31:0] addr);
        logic [RW-1:0] r;
        logic [2:0]    a;
        a = addr[2:0];
        for (int j = 0; j < MD; j++) r[j*DW +: DW] = mem_a[a][j];
        return r;
    endfunction

    function automatic logic [RW-1:0] row_b(input logic [31:0] addr);
        logic [RW-1:0] r;
        logic [2:0]    a;
        a = addr[2:0];
        for (int j = 0; j < MD; j++) r[j*DW +: DW] = mem_b[a][j];
        return r;
    endfunction

    always @(posedge clk) begin
        a_rd1      <= row_a(a_addr1);
        b_rd1      <= row_b(b_addr1);
        a_pipe3[0] <= row_a(a_addr3);
        b_pipe3[0] <= row_b(b_addr3);
        a_pipe3[1] <= a_pipe3[0];
        b_pipe3[1] <= b_pipe3[0];
        a_pipe3[2] <= a_pipe3[1];
        b_pipe3[2] <= b_pipe3[1];
    end

    task automatic check_eq(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Independent reference: plain integer dot products, then clamp or wrap.
    function automatic logic [RW-1:0] ref_row(input int i, input int dk, input int dn,
                                              input bit sgn, input bit sat);
        logic [RW-1:0] r;
        longint        acc, av, bv;
        logic [DW-1:0] o;
        r = '0;
        for (int j = 0; j <= dn; j++) begin
            acc = 0;
            for (int kk = 0; kk <= dk; kk++) begin
                av = sgn ? longint'($signed(mem_a[i][kk])) : longint'(mem_a[i][kk]);
                bv = sgn ? longint'($signed(mem_b[kk][j])) : longint'(mem_b[kk][j]);
                acc += av * bv;
            end
            if (sat && sgn) o = (acc > 32767) ? 16'h7FFF : (acc < -32768) ? 16'h8000 : acc[15:0];
            else if (sat)   o = (acc > 65535) ? 16'hFFFF : acc[15:0];
            else            o = acc[15:0];
            r[j*DW +: DW] = o;
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (!reset && c_write1 && ready) begin
            if (q1.size() == 0) check_eq("l1_unexpected_write", c_write1, 0);
            else begin
                e1 = q1.pop_front();
                check_eq("l1_c_addr", c_addr1, e1.addr);
                check_eq("l1_c_data", c_data1, e1.data);
                check_eq("l1_c_mask", c_mask1, e1.mask);
            end
        end
        if (!reset && c_write3 && ready) begin
            if (q3.size() == 0) check_eq("l3_unexpected_write", c_write3, 0);
            else begin
                e3 = q3.pop_front();
                check_eq("l3_c_addr", c_addr3, e3.addr);
                check_eq("l3_c_data", c_data3, e3.data);
                check_eq("l3_c_mask", c_mask3, e3.mask);
            end
        end
    end

    task automatic run_job(input int m, input int k, input int n, input bit sgn, input bit sat,
                           input int stall, input bit poke);
        exp_t          e;
        int            cyc, d1, d3, scnt;
        bit            s1, s3;
        logic [RW-1:0] h_data;
        logic [31:0]   h_a, h_b, h_c;
        logic [MD-1:0] h_mask;
        for (int i = 0; i <= m; i++) begin
            e.addr = i;
            e.data = ref_row(i, k, n, sgn, sat);
            e.mask = MD'((1 << (n + 1)) - 1);
            q1.push_back(e);
            q3.push_back(e);
        end
        dim_m = 3'(m); dim_k = 3'(k); dim_n = 3'(n);
        signed_mode = sgn; sat_mode = sat;
        if (stall > 0) ready = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1; d1 = 0; d3 = 0; s1 = 0; s3 = 0; scnt = 0;
        h_data = '0; h_a = '0; h_b = '0; h_c = '0; h_mask = '0;
        while (!(s1 && s3) && cyc < 3000) begin
            if (done1 && !s1) begin
                s1 = 1; d1 = cyc;
                check_eq("busy_low_at_done", busy1, 0);
            end
            if (s1 && cyc == d1 + 1) check_eq("done_one_cycle", done1, 0);
            if (done3 && !s3) begin s3 = 1; d3 = cyc; end
            if (poke && cyc == 2) begin
                start = 1'b1; dim_m = 3'd7; dim_k = 3'd7; dim_n = 3'd7; sat_mode = ~sat;
            end else begin
                start = 1'b0; dim_m = 3'(m); dim_k = 3'(k); dim_n = 3'(n); sat_mode = sat;
            end
            if (stall > 0 && c_write1 && !ready) begin
                if (scnt == 0) begin
                    h_data = c_data1; h_a = a_addr1; h_b = b_addr1; h_c = c_addr1; h_mask = c_mask1;
                end else begin
                    check_eq("stall_c_data", c_data1, h_data);
                    check_eq("stall_c_addr", c_addr1, h_c);
                    check_eq("stall_c_mask", c_mask1, h_mask);
                    check_eq("stall_a_addr", a_addr1, h_a);
                    check_eq("stall_b_addr", b_addr1, h_b);
                end
                if (scnt == stall) ready = 1'b1;
                else scnt++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        ready = 1'b1;
        check_eq("l1_done_seen", s1, 1);
        check_eq("l3_done_seen", s3, 1);
        check_eq("l1_job_cycles", d1, (m + 1) * (k + 3) + 1 + stall);
        if (stall == 0) check_eq("l3_job_cycles", d3, (m + 1) * (k + 5) + 1);
        check_eq("l1_rows_left", q1.size(), 0);
        check_eq("l3_rows_left", q3.size(), 0);
    endtask

    task automatic clear_mem();
        for (int r = 0; r < MD; r++)
            for (int c = 0; c < MD; c++) begin
                mem_a[r][c] = '0;
                mem_b[r][c] = '0;
            end
    endtask

    task automatic rand_mem();
        for (int r = 0; r < MD; r++)
            for (int c = 0; c < MD; c++) begin
                mem_a[r][c] = DW'($urandom);
                mem_b[r][c] = DW'($urandom);
            end
    endtask

    initial begin
        clear_mem();
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check_eq("rst_busy", busy1, 0);
        check_eq("rst_done", done1, 0);
        check_eq("rst_c_write", c_write1, 0);
        check_eq("rst_a_addr", a_addr1, 0);
        check_eq("rst_b_addr", b_addr1, 0);
        check_eq("rst_c_addr", c_addr1, 0);

        // 2x2x2 unsigned
        mem_a[0][0] = 1; mem_a[0][1] = 2; mem_a[1][0] = 3; mem_a[1][1] = 4;
        mem_b[0][0] = 5; mem_b[0][1] = 6; mem_b[1][0] = 7; mem_b[1][1] = 8;
        e1.data = ref_row(0, 1, 1, 0, 0);
        check_eq("ref_row0", e1.data[31:0], {16'd22, 16'd19});
        run_job(1, 1, 1, 0, 0, 0, 0);

        // Same job with a 5-cycle write stall and a start pulse while busy
        run_job(1, 1, 1, 0, 0, 5, 1);

        // Signed 1x3x1; unused B lanes hold junk that must be masked off
        rand_mem();
        mem_a[0][0] = 16'hFFFE; mem_a[0][1] = 16'd3; mem_a[0][2] = 16'hFFFF;
        mem_b[0][0] = 16'd4;    mem_b[1][0] = 16'd5; mem_b[2][0] = 16'd6;
        e1.data = ref_row(0, 2, 0, 1, 0);
        check_eq("ref_signed", e1.data, {{7{16'd0}}, 16'd1});
        run_job(0, 2, 0, 1, 0, 0, 0);

        // Full 8x8x8 of 0xFFFF, saturated then wrapped
        for (int r = 0; r < MD; r++)
            for (int c = 0; c < MD; c++) begin
                mem_a[r][c] = 16'hFFFF;
                mem_b[r][c] = 16'hFFFF;
            end
        run_job(7, 7, 7, 0, 1, 0, 0);
        run_job(7, 7, 7, 0, 0, 0, 0);

        // Reset in the middle of ISSUE, then a fresh 1x1x1 job
        rand_mem();
        dim_m = 3'd1; dim_k = 3'd3; dim_n = 3'd1; signed_mode = 1'b0; sat_mode = 1'b0;
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        check_eq("midrst_busy1", busy1, 0);
        check_eq("midrst_busy3", busy3, 0);
        check_eq("midrst_c_write", c_write1, 0);
        check_eq("midrst_b_addr", b_addr1, 0);
        clear_mem();
        mem_a[0][0] = 16'd3; mem_b[0][0] = 16'd4;
        run_job(0, 0, 0, 0, 0, 0, 0);

        // Random signed 3x4x2 (wrap and clamp), then random shapes and modes
        rand_mem();
        run_job(2, 3, 1, 1, 0, 0, 0);
        run_job(2, 3, 1, 1, 1, 0, 0);
        for (int t = 0; t < 4; t++) begin
            rand_mem();
            run_job($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 0);
        end

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/matrix_multiply_engine.md
# matrix_multiply_engine

Parametrised rectangular matrix multiplier computing C[M][N] = A[M][K] × B[K][N], row by row. A and B sit in row-wide memories; C is written one full row per beat. It adds rectangular shapes, configurable read latency, signed/unsigned arithmetic, optional saturation and a write-side backpressure handshake. It is the next-generation compute core behind the matrix memory fabric.

## Interface
- MAX_DIM, 8, max of M, K, N; also lane count
- DIM_WIDTH, $clog2(MAX_DIM), width of size fields (encoded as dimension − 1)
- ADDR_WIDTH, 32, memory address width
- DATA_WIDTH, 16, element width
- ACC_WIDTH, 2*DATA_WIDTH+$clog2(MAX_DIM), accumulator width
- READ_LATENCY, 1, cycles from address to read data (≥1)

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- start  input  1  begin job (sampled in IDLE only)
- dim_m / dim_k / dim_n  input  DIM_WIDTH each  dimensions minus one, latched at start
- signed_mode  input  1  1 = two's-complement operands, latched at start
- sat_mode  input  1  1 = clamp result to DATA_WIDTH, 0 = truncate; latched at start
- mat_a_address  output  ADDR_WIDTH  A row index i, zero-extended
- mat_a_read_data  input  DATA_WIDTH×MAX_DIM  A row, valid READ_LATENCY after address
- mat_b_address  output  ADDR_WIDTH  B row index k, zero-extended
- mat_b_read_data  input  DATA_WIDTH×MAX_DIM  B row, valid READ_LATENCY after address
- mat_c_write  output  1  C row write request
- mat_c_ready  input  1  write accepted when mat_c_write && mat_c_ready
- mat_c_address  output  ADDR_WIDTH  C row index i
- mat_c_write_data  output  DATA_WIDTH×MAX_DIM  C row
- mat_c_lane_mask  output  MAX_DIM  bit j high for j ≤ dim_n
- busy  output  1  state ≠ IDLE
- done  output  1  one-cycle pulse at job end

## Operation
- States: IDLE → ISSUE → DRAIN → WRITE → (ISSUE for next row | IDLE).
- IDLE: start=1 latches config; i=0, k=0; next ISSUE. start while busy is ignored.
- ISSUE: drive A address i, B address k each cycle; k counts 0..dim_k; after k=dim_k go DRAIN. A tag pipeline of depth READ_LATENCY carries (valid, first) beside the reads.
- Lane j on tagged data: first beat acc ← A[i][k]·B[k][j]; otherwise acc ← acc + A[i][k]·B[k][j]. The A element is mat_a_read_data[k_tag]. Products are sign- or zero-extended to ACC_WIDTH per signed_mode.
- DRAIN: READ_LATENCY cycles, then WRITE.
- WRITE: mat_c_write=1 and data held stable until ready. On handshake: if i=dim_m go IDLE and pulse done; else i++, k=0, go ISSUE.
- Output conversion: sat_mode=0 takes acc[DATA_WIDTH-1:0]. sat_mode=1 clamps to [−2^(DW−1), 2^(DW−1)−1] when signed, or [0, 2^DW−1] when unsigned. Lanes j > dim_n output 0.
- Reset: state IDLE. Accumulators, tags, mat_c_write, busy, done and all addresses are 0. Reset mid-job aborts it; in-flight read data is discarded.

## Timing
- Row time with ready held high: (dim_k+1) + READ_LATENCY + 1 cycles.
- Job time: (dim_m+1)×row time, from the start cycle to the final handshake.
- done is high in the cycle after the final handshake; busy is low in that same cycle.
- A new start is accepted in the done cycle.
- Ready low stalls WRITE indefinitely with no reads issued. Address, data and mask stay stable.
- 1×1×1 job (all dims 0): ISSUE for 1 cycle.

## Structure
- Package matrix_pkg: state enum (IDLE, ISSUE, DRAIN, WRITE), tag struct {valid, first, k}, and saturate function.
- Sub-module mac_lane: one lane with ports clk, reset, en, first, signed_mode, a, b, acc. Instantiated MAX_DIM times.
- Top level holds FSM, counters, tag pipeline, conversion/mask logic.

## Test plan
- 2×2×2 unsigned, A=[[1,2],[3,4]], B=[[5,6],[7,8]], ready=1 -> C rows [19,22], [43,50]; done 9 cycles after start (L=1).
- Signed 1×3×1, A=[-2,3,-1], B=[4,5,6]ᵀ -> C[0][0]=1; lanes 1..7 = 0; mask=8'b0000_0001.
- sat_mode=1, unsigned, A=B=all 0xFFFF, 8×8×8 -> all 0xFFFF. Repeat with sat_mode=0 -> low 16 bits 0x0008.
- mat_c_ready low 5 cycles on row 0 -> write held stable; no address change; total time +5 cycles.
- Reset asserted mid-ISSUE, then a new 1×1×1 job with A=3, B=4 -> C=12, with no stale accumulation; start asserted during busy is ignored.
- READ_LATENCY=3, 3×4×2 random signed data -> C matches the reference model on all rows.
